// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: software-access front end for a register block.
// Takes one bus request at a time, decodes it to a register index, issues a
// single-cycle one-hot read or write strobe, samples the read word in that
// same cycle and returns it on a response channel.
//
// Handshakes: a transfer happens on any rising clk edge where both valid and
// ready are high (req_vld/req_rdy, ack_vld/ack_rdy). A valid may drop before
// it is accepted. Once ack_vld is raised, it and its payload stay stable
// until ack_rdy is seen.
module reg_access_ctrl #(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    REG_NUM    = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 12'h100
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_vld,
  output logic                          req_rdy,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic                          req_wr,
  input  logic [DATA_WIDTH-1:0]         req_wdata,
  output logic [REG_NUM-1:0]            sw_rd,
  output logic [REG_NUM-1:0]            sw_wr,
  output logic [DATA_WIDTH-1:0]         sw_wr_data,
  input  logic [REG_NUM*DATA_WIDTH-1:0] reg_rd_data,
  output logic                          ack_vld,
  input  logic                          ack_rdy,
  output logic [DATA_WIDTH-1:0]         ack_rd_data,
  output logic                          ack_err
);

  localparam int IDX_WIDTH = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam logic [ADDR_WIDTH-3:0] REG_NUM_W = REG_NUM[ADDR_WIDTH-3:0];

  // Parameter sanity: word addressing assumes 32-bit registers.
  if (DATA_WIDTH != 32) begin : g_bad_dw
    $error("reg_access_ctrl: DATA_WIDTH must be 32");
  end
  if (REG_NUM < 1) begin : g_bad_rn
    $error("reg_access_ctrl: REG_NUM must be at least 1");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $error("reg_access_ctrl: BASE_ADDR must be 4-byte aligned");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // FSM state, kept as a plain named signal so checkers can bind to it.
  state_t                state;

  logic [ADDR_WIDTH-1:0] lat_addr;
  logic                  lat_wr;
  logic [DATA_WIDTH-1:0] lat_wdata;

  logic [ADDR_WIDTH:0]   offset;
  logic                  borrow;
  logic [ADDR_WIDTH-3:0] word_off;
  logic                  hit;
  logic [IDX_WIDTH-1:0]  idx;
  logic [DATA_WIDTH-1:0] rd_word;

  // Decode the latched address; the extra top bit catches addresses below base.
  assign offset   = {1'b0, lat_addr} - {1'b0, BASE_ADDR};
  assign borrow   = offset[ADDR_WIDTH];
  assign word_off = offset[ADDR_WIDTH-1:2];
  assign hit      = !borrow && (offset[1:0] == 2'b00) && (word_off < REG_NUM_W);
  assign idx      = offset[IDX_WIDTH+1:2];

  // Write data follows the latched request, so it is stable until the next accept.
  assign sw_wr_data = lat_wdata;

  // Select the addressed register's current read word.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (idx == i[IDX_WIDTH-1:0]) begin
        rd_word = reg_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // One-hot strobes, only during ACCESS and only on a decode hit.
  always_comb begin
    sw_rd = '0;
    sw_wr = '0;
    if (state == ACCESS && hit) begin
      sw_rd[idx] = !lat_wr;
      sw_wr[idx] = lat_wr;
    end
  end

  // Control FSM: accept, strobe for one cycle, then hold the response until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_rdy     <= 1'b1;
      lat_addr    <= '0;
      lat_wr      <= 1'b0;
      lat_wdata   <= '0;
      ack_vld     <= 1'b0;
      ack_rd_data <= '0;
      ack_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_vld && req_rdy) begin
            lat_addr  <= req_addr;
            lat_wr    <= req_wr;
            lat_wdata <= req_wdata;
            req_rdy   <= 1'b0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // Read word is sampled alongside sw_rd, i.e. before any read side effect.
          ack_rd_data <= (hit && !lat_wr) ? rd_word : '0;
          ack_err     <= !hit;
          ack_vld     <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (ack_rdy) begin
            ack_vld <= 1'b0;
            req_rdy <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          ack_vld <= 1'b0;
          req_rdy <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// tb_reg_access_ctrl: directed bench for reg_access_ctrl with an expected-
// response queue filled at request time and drained when ack_vld appears.
module tb_reg_access_ctrl;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int RN = 4;
  localparam int BASE = 'h100;

  logic             clk;
  logic             rst_n;
  logic             req_vld;
  logic             req_rdy;
  logic [AW-1:0]    req_addr;
  logic             req_wr;
  logic [DW-1:0]    req_wdata;
  logic [RN-1:0]    sw_rd;
  logic [RN-1:0]    sw_wr;
  logic [DW-1:0]    sw_wr_data;
  logic [RN*DW-1:0] reg_rd_data;
  logic             ack_vld;
  logic             ack_rdy;
  logic [DW-1:0]    ack_rd_data;
  logic             ack_err;

  logic [DW-1:0]    regs [RN];
  logic [DW:0]      exp_q [$];   // {err, rd_data}
  int               checks;
  int               errors;

  assign reg_rd_data = {regs[3], regs[2], regs[1], regs[0]};

  reg_access_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_NUM(RN), .BASE_ADDR(12'h100)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr),
    .req_wr(req_wr), .req_wdata(req_wdata),
    .sw_rd(sw_rd), .sw_wr(sw_wr), .sw_wr_data(sw_wr_data),
    .reg_rd_data(reg_rd_data),
    .ack_vld(ack_vld), .ack_rdy(ack_rdy),
    .ack_rd_data(ack_rd_data), .ack_err(ack_err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode, written from the address map.
  task automatic model(input int addr, output logic hit, output int idx);
    hit = (addr >= BASE) && (addr % 4 == 0) && ((addr - BASE) / 4 < RN);
    idx = hit ? (addr - BASE) / 4 : 0;
  endtask

  // Pop the queue head and compare against the presented response.
  task automatic check_resp(input string tag);
    logic [DW:0] e;
    for (int k = 0; k < 10 && !ack_vld; k++) @(negedge clk);
    check({tag, "_ack_vld"}, ack_vld, 1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_nonempty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_ack_err"}, ack_err, e[DW]);
      check({tag, "_ack_rd_data"}, ack_rd_data, e[DW-1:0]);
    end
  endtask

  // Full access with ack_rdy high; called and returns on a falling edge in IDLE.
  task automatic access(input string tag, input int addr, input logic wr, input logic [DW-1:0] wdata);
    logic         hit;
    int           idx;
    logic [RN-1:0] m;
    model(addr, hit, idx);
    m = '0;
    if (hit) m[idx] = 1'b1;
    check({tag, "_req_rdy"}, req_rdy, 1);
    req_vld = 1'b1; req_addr = addr[AW-1:0]; req_wr = wr; req_wdata = wdata;
    exp_q.push_back({!hit, (hit && !wr) ? regs[idx] : '0});
    @(posedge clk); @(negedge clk);
    req_vld = 1'b0;
    check({tag, "_sw_rd"}, sw_rd, wr ? '0 : m);
    check({tag, "_sw_wr"}, sw_wr, wr ? m : '0);
    if (wr) check({tag, "_sw_wr_data"}, sw_wr_data, wdata);
    @(posedge clk); @(negedge clk);
    // Disturb the read word after the strobe cycle; the response must not follow it.
    if (hit && !wr) regs[idx] = regs[idx] ^ 32'hFFFF_0000;
    check_resp(tag);
    check({tag, "_strobe_off"}, {sw_rd, sw_wr}, 0);
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    logic [DW:0] e;
    checks = 0; errors = 0;
    rst_n = 1'b0; req_vld = 1'b0; req_addr = '0; req_wr = 1'b0; req_wdata = '0;
    ack_rdy = 1'b1;
    regs[0] = 32'h0000_1111; regs[1] = 32'h2222_3333;
    regs[2] = 32'hDEAD_BEEF; regs[3] = 32'h4444_5555;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_req_rdy", req_rdy, 1);
    check("rst_ack_vld", ack_vld, 0);
    check("rst_strobes", {sw_rd, sw_wr}, 0);
    check("rst_sw_wr_data", sw_wr_data, 0);
    check("rst_ack_data", {ack_err, ack_rd_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Read hit, write hit, then the three error flavours
    access("rd_hit", 'h108, 1'b0, '0);
    access("wr_hit", 'h10C, 1'b1, 32'h1234_5678);
    access("err_past_end", 'h110, 1'b0, '0);
    access("err_below_base", 'h0FC, 1'b0, '0);
    access("err_misaligned", 'h102, 1'b1, 32'hA5A5_A5A5);

    // Back-to-back reads; each access() re-checks req_rdy exactly 3 cycles on
    for (int i = 0; i < 4; i++) begin
      regs[i] = $urandom_range(0, 32'h7FFF_FFFF);
      access("b2b_rd", BASE + 4 * i, 1'b0, '0);
    end

    // Backpressure: response held while the next request waits
    ack_rdy = 1'b0;
    req_vld = 1'b1; req_addr = 12'h100; req_wr = 1'b0; req_wdata = '0;
    exp_q.push_back({1'b0, regs[0]});
    e = {1'b0, regs[0]};
    @(posedge clk); @(negedge clk);
    check("bp_sw_rd", sw_rd, 4'b0001);
    req_addr = 12'h104; req_wr = 1'b1; req_wdata = 32'hCAFE_F00D;
    @(posedge clk); @(negedge clk);
    check_resp("bp_first");
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_vld", ack_vld, 1);
      check("bp_hold_data", {ack_err, ack_rd_data}, e);
      check("bp_req_rdy", req_rdy, 0);
      check("bp_no_strobe", {sw_rd, sw_wr}, 0);
      if (k < 4) begin @(posedge clk); @(negedge clk); end
    end
    ack_rdy = 1'b1;
    exp_q.push_back({1'b0, 32'h0});
    @(posedge clk); @(negedge clk);
    check("bp_req_rdy_back", req_rdy, 1);
    @(posedge clk); @(negedge clk);
    req_vld = 1'b0;
    check("bp_next_sw_wr", sw_wr, 4'b0010);
    check("bp_next_wdata", sw_wr_data, 32'hCAFE_F00D);
    @(posedge clk); @(negedge clk);
    check_resp("bp_second");
    @(posedge clk); @(negedge clk);

    // Reset during ACCESS: strobe dropped, no response ever
    req_vld = 1'b1; req_addr = 12'h108; req_wr = 1'b0;
    @(posedge clk); @(negedge clk);
    req_vld = 1'b0;
    check("mid_rst_pre_strobe", sw_rd, 4'b0100);
    rst_n = 1'b0;
    #1;
    check("mid_rst_strobes", {sw_rd, sw_wr}, 0);
    check("mid_rst_req_rdy", req_rdy, 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("mid_rst_no_ack", ack_vld, 0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_no_ack", ack_vld, 0);
    end
    access("post_rst_rd", 'h108, 1'b0, '0);

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
